gray2bin_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Gray-to-binary conversion datapath among NREQ requesters. Typical clients are NoC ports and FIFO pointer logic holding Gray-coded indices. The block accepts one Gray word per transaction over a valid/ready handshake, converts it, and returns the binary result tagged with the requester index on a single response channel with backpressure.

---
 rtl/gray2bin_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gray2bin_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_arbiter.sv
// ---------------------------------------------------------------------------
// gray2bin_arbiter
//
// Round-robin arbiter that shares one Gray-to-binary converter among NREQ
// requesters. One Gray word is accepted per transaction over a valid/ready
// handshake. The binary result comes back on a single response channel,
// tagged with the index of the requester that was served, and the response
// channel supports backpressure.
//
// Build option:
//   GRAY2BIN_ARB_FAST_EN  - when defined, the CONV state is skipped. The word
//                           is converted at acceptance, so the response is
//                           valid one edge earlier.
//
// Parameters:
//   WIDTH  Gray/binary word width (>= 1)
//   NREQ   number of requesters (>= 2)
//
// Ports:
//   clk        clock; all logic is on the rising edge
//   srst       synchronous active-high reset
//   req_valid  [NREQ]        per-requester request valid
//   req_gray   [NREQ*WIDTH]  requester k word at [k*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot grant while IDLE, otherwise zero
//   rsp_valid                response valid
//   rsp_id     [IDW]         index of the requester that was served
//   rsp_bin    [WIDTH]       converted binary word
//   rsp_ready                downstream accepts the response
// ---------------------------------------------------------------------------
module gray2bin_arbiter #(
    parameter int  WIDTH = 4,
    parameter int  NREQ  = 4,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_bin,
    input  logic                  rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDW-1:0]   last_grant_r;
    logic [IDW-1:0]   grant_idx_s;
    logic             grant_found_s;
    logic [WIDTH-1:0] gnt_word_s;
    logic             accept_s;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_bin_r;
`ifndef GRAY2BIN_ARB_FAST_EN
    logic [WIDTH-1:0] gray_r;
    logic [IDW-1:0]   id_r;
`endif

    // Each binary bit is the XOR of its Gray bit with all Gray bits above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Round-robin pick: scan upward from last_grant+1 and wrap; the first hit wins.
    always_comb begin
        logic [IDW-1:0] cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        cand_v        = {IDW{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            cand_v = IDW'((int'(last_grant_r) + i) % NREQ);
            if (!grant_found_s && req_valid[cand_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Select the granted requester's word and drive the one-hot ready.
    always_comb begin
        gnt_word_s = {WIDTH{1'b0}};
        req_ready  = {NREQ{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx_s == IDW'(k)) begin
                gnt_word_s = req_gray[k*WIDTH +: WIDTH];
            end else begin
                gnt_word_s = gnt_word_s;
            end
            req_ready[k] = (state_r == IDLE) && !srst && grant_found_s &&
                           (grant_idx_s == IDW'(k));
        end
    end

    assign accept_s = |(req_valid & req_ready);

    // Next-state logic for the IDLE -> (CONV) -> RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef GRAY2BIN_ARB_FAST_EN
                    state_nxt_s = RESP;
`else
                    state_nxt_s = CONV;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, round-robin pointer, captured request and response registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r      <= IDLE;
            last_grant_r <= IDW'(NREQ - 1);
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {IDW{1'b0}};
            rsp_bin_r    <= {WIDTH{1'b0}};
`ifndef GRAY2BIN_ARB_FAST_EN
            gray_r       <= {WIDTH{1'b0}};
            id_r         <= {IDW{1'b0}};
`endif
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                last_grant_r <= grant_idx_s;
`ifdef GRAY2BIN_ARB_FAST_EN
                rsp_bin_r    <= gray2bin(gnt_word_s);
                rsp_id_r     <= grant_idx_s;
                rsp_valid_r  <= 1'b1;
`else
                gray_r       <= gnt_word_s;
                id_r         <= grant_idx_s;
            end else if (state_r == CONV) begin
                rsp_bin_r    <= gray2bin(gray_r);
                rsp_id_r     <= id_r;
                rsp_valid_r  <= 1'b1;
`endif
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid_r  <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_bin   = rsp_bin_r;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Self-checking bench for gray2bin_arbiter. The stimulus driver advances a
// transaction-level reference model and pushes each expected response onto a
// queue. A separate monitor checks every presented response against the head
// of that queue.
module tb_gray2bin_arbiter;
    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef GRAY2BIN_ARB_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           srst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_gray;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_bin;
    logic           rsp_ready;

    gray2bin_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .srst(srst), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_bin(rsp_bin), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [W-1:0] bin; } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    // Reference model state
    int m_last;      // last granted requester
    bit m_free;      // block can take a request this cycle
    int m_delay;     // pending conversion cycles
    bit m_rv;        // response should be visible
    bit m_acc;       // an acceptance happened on the last edge
    bit mon_en = 1'b0;
    int dut_served[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Binary bit i is the parity of all Gray bits at position i and above.
    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] word_of(input int k);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) if (i == k) w = req_gray[i*W +: W];
        return w;
    endfunction

    function automatic int m_grant();
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check the handshake at the falling edge, then advance the model.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        g = m_grant();
        exp_rdy = '0;
        if (!srst && m_free && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, m_rv);
        for (int k = 0; k < N; k++) if (req_valid[k] && req_ready[k]) dut_served[k]++;
        @(posedge clk);
        m_acc = 1'b0;
        if (srst) begin
            m_free = 1'b1; m_delay = 0; m_rv = 1'b0; m_last = N - 1;
            exp_q.delete();
        end else if (m_rv) begin
            if (rsp_ready) begin m_rv = 1'b0; m_free = 1'b1; end
        end else if (m_delay > 0) begin
            m_delay = 0; m_rv = 1'b1;
        end else if (m_free && g >= 0) begin
            e.id = g; e.bin = ref_bin(word_of(g));
            exp_q.push_back(e);
            m_last = g; m_free = 1'b0; m_acc = 1'b1;
            if (FAST) m_rv = 1'b1; else m_delay = 1;
        end
        #1;
    endtask

    // Present a request set until the model sees an acceptance, then drop it.
    task automatic send(input logic [N-1:0] v);
        int budget;
        budget = 20;
        req_valid = v;
        do begin
            step();
            budget--;
        end while (!m_acc && budget > 0);
        if (!m_acc) chk("accept_timeout", m_acc, 1'b1);
        req_valid = '0;
    endtask

    // Response monitor: every presented response must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_bin", rsp_bin, exp_q[0].bin);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int total, budget;
        srst = 1'b1; req_valid = '0; req_gray = '0; rsp_ready = 1'b0;
        m_last = N - 1; m_free = 1'b1; m_delay = 0; m_rv = 1'b0; m_acc = 1'b0;
        for (int k = 0; k < N; k++) dut_served[k] = 0;
        #1;
        step(); step();
        chk("reset_rsp_bin", rsp_bin, 4'b0000);
        chk("reset_rsp_id", rsp_id, 2'd0);
        srst = 1'b0;
        mon_en = 1'b1;

        // Single request from requester 0
        rsp_ready = 1'b1;
        req_gray = 16'h000D;
        send(4'b0001);
        repeat (3) step();

        // All 16 Gray codes from requester 2
        for (int g = 0; g < 16; g++) begin
            req_gray = 16'(g) << (2 * W);
            send(4'b0100);
        end
        repeat (3) step();

        // Round-robin with all requesters active
        for (int k = 0; k < N; k++) dut_served[k] = 0;
        req_valid = 4'b1111;
        total = 0; budget = 100;
        while (total < 8 && budget > 0) begin
            req_gray = 16'($urandom());
            step();
            total = 0;
            for (int k = 0; k < N; k++) total += dut_served[k];
            budget--;
        end
        for (int k = 0; k < N; k++) chk("rr_fairness", 32'(dut_served[k]), 32'd2);

        // Backpressure
        rsp_ready = 1'b0;
        repeat (6) step();
        rsp_ready = 1'b1;
        repeat (6) step();

        // Reset while a transaction is in flight
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        budget = 20;
        while (!(m_delay > 0 || m_rv) && budget > 0) begin step(); budget--; end
        srst = 1'b1;
        step();
        srst = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) step();

        // Sparse requests across the wrap point
        req_valid = '0; srst = 1'b1; step(); srst = 1'b0;
        req_gray = 16'($urandom());
        send(4'b1000);
        send(4'b0100);
        send(4'b0110);
        repeat (3) step();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom());
            req_gray  = 16'($urandom());
            rsp_ready = ($urandom_range(0, 9) < 7);
            srst      = ($urandom_range(0, 49) == 0);
            step();
        end

        // Drain
        srst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (6) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
